// File: rtl/lego_rx_filter.sv
// Ethernet RX filter for Lego frames: buffers the two header beats, checks destination MAC
// and EtherType, then replays the header and streams the rest of a matching frame.
module lego_rx_filter #(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] LEGO_ETYPE = 16'h88B5
) (
  input  logic        apclk,
  input  logic        apresetn,
  input  logic [63:0] fromMac_axis_tdata,
  input  logic [7:0]  fromMac_axis_tkeep,
  input  logic [63:0] fromMac_axis_tuser,
  input  logic        fromMac_axis_tlast,
  input  logic        fromMac_axis_tvalid,
  output logic        fromMac_axis_tready,
  output logic [63:0] toHdr_axis_tdata,
  output logic [7:0]  toHdr_axis_tkeep,
  output logic [63:0] toHdr_axis_tuser,
  output logic        toHdr_axis_tlast,
  output logic        toHdr_axis_tvalid,
  input  logic        toHdr_axis_tready,
  input  logic        cfg_promisc,
  output logic [31:0] stat_pass_cnt,
  output logic [31:0] stat_drop_cnt
);

  typedef enum logic [2:0] {HDR0, HDR1, EMIT0, EMIT1, STREAM, DROP} state_e;

  state_e      state_q;
  logic [63:0] data0_q, data1_q;
  logic [7:0]  keep0_q, keep1_q;
  logic [63:0] user0_q, user1_q;
  logic        last0_q, last1_q;
  logic [31:0] passCnt_q, dropCnt_q;
  logic [31:0] passCnt_d, dropCnt_d;

  logic inAccept;
  logic dstMatch;
  logic hdrMatch;

  assign inAccept  = fromMac_axis_tvalid & fromMac_axis_tready;
  assign dstMatch  = (data0_q[63:16] == LOCAL_MAC) | (data0_q[63:16] == 48'hFFFF_FFFF_FFFF) |
                     cfg_promisc;
  assign hdrMatch  = dstMatch & (fromMac_axis_tdata[31:16] == LEGO_ETYPE);
  assign passCnt_d = passCnt_q + 32'd1;
  assign dropCnt_d = dropCnt_q + 32'd1;

  assign stat_pass_cnt = passCnt_q;
  assign stat_drop_cnt = dropCnt_q;

  // tready is gated by the reset itself so it stays low for the whole time reset is held.
  always_comb begin
    fromMac_axis_tready = 1'b0;
    toHdr_axis_tvalid   = 1'b0;
    toHdr_axis_tdata    = 64'd0;
    toHdr_axis_tkeep    = 8'd0;
    toHdr_axis_tuser    = 64'd0;
    toHdr_axis_tlast    = 1'b0;
    case (state_q)
      HDR0, HDR1, DROP: fromMac_axis_tready = apresetn;
      EMIT0: begin
        toHdr_axis_tvalid = 1'b1;
        toHdr_axis_tdata  = data0_q;
        toHdr_axis_tkeep  = keep0_q;
        toHdr_axis_tuser  = user0_q;
        toHdr_axis_tlast  = last0_q;
      end
      EMIT1: begin
        toHdr_axis_tvalid = 1'b1;
        toHdr_axis_tdata  = data1_q;
        toHdr_axis_tkeep  = keep1_q;
        toHdr_axis_tuser  = user1_q;
        toHdr_axis_tlast  = last1_q;
      end
      STREAM: begin
        fromMac_axis_tready = toHdr_axis_tready;
        toHdr_axis_tvalid   = fromMac_axis_tvalid;
        toHdr_axis_tdata    = fromMac_axis_tdata;
        toHdr_axis_tkeep    = fromMac_axis_tkeep;
        toHdr_axis_tuser    = fromMac_axis_tuser;
        toHdr_axis_tlast    = fromMac_axis_tlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      state_q   <= HDR0;
      data0_q   <= 64'd0;
      keep0_q   <= 8'd0;
      user0_q   <= 64'd0;
      last0_q   <= 1'b0;
      data1_q   <= 64'd0;
      keep1_q   <= 8'd0;
      user1_q   <= 64'd0;
      last1_q   <= 1'b0;
      passCnt_q <= 32'd0;
      dropCnt_q <= 32'd0;
    end else begin
      case (state_q)
        HDR0: begin
          if (inAccept) begin
            data0_q <= fromMac_axis_tdata;
            keep0_q <= fromMac_axis_tkeep;
            user0_q <= fromMac_axis_tuser;
            last0_q <= fromMac_axis_tlast;
            if (fromMac_axis_tlast) dropCnt_q <= dropCnt_d;
            else                    state_q   <= HDR1;
          end
        end
        HDR1: begin
          if (inAccept) begin
            data1_q <= fromMac_axis_tdata;
            keep1_q <= fromMac_axis_tkeep;
            user1_q <= fromMac_axis_tuser;
            last1_q <= fromMac_axis_tlast;
            if (hdrMatch) begin
              state_q <= EMIT0;
            end else begin
              dropCnt_q <= dropCnt_d;
              state_q   <= fromMac_axis_tlast ? HDR0 : DROP;
            end
          end
        end
        EMIT0: begin
          if (toHdr_axis_tready) state_q <= EMIT1;
        end
        // A two-beat frame ends here; longer frames hand over to pass-through with no bubble.
        EMIT1: begin
          if (toHdr_axis_tready) begin
            if (last1_q) begin
              passCnt_q <= passCnt_d;
              state_q   <= HDR0;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (inAccept && fromMac_axis_tlast) begin
            passCnt_q <= passCnt_d;
            state_q   <= HDR0;
          end
        end
        DROP: begin
          if (inAccept && fromMac_axis_tlast) state_q <= HDR0;
        end
        default: state_q <= HDR0;
      endcase
    end
  end

endmodule
